// File: rtl/spi_counter_ctrl_n_if.sv
// Signal bundle between a run/stop/clear request source and spi_counter_ctrl_n.
// The master side drives the requests; the slave side returns the counter controls.
interface spi_counter_ctrl_n_if #(
   parameter int NCH = 4
);
   logic [NCH-1:0]   i_runstop;
   logic [NCH-1:0]   i_clear;
   logic             i_global_clear;
   logic [NCH-1:0]   o_runstop;
   logic [NCH-1:0]   o_clear;
   logic             o_any_run;
   logic [2*NCH-1:0] o_dbg_state;

   modport master (
      output i_runstop, i_clear, i_global_clear,
      input  o_runstop, o_clear, o_any_run, o_dbg_state
   );

   modport slave (
      input  i_runstop, i_clear, i_global_clear,
      output o_runstop, o_clear, o_any_run, o_dbg_state
   );
endinterface

// File: rtl/spi_counter_ctrl_n.sv
// Per-channel STOP/RUN/CLEAR controller that drives counter enables and clears.
// o_clear is stretched to at least CLR_PULSE cycles; clear always wins over run/stop.
module spi_counter_ctrl_n #(
   parameter int NCH         = 4,
   parameter int TOGGLE_MODE = 0,
   parameter int CLR_PULSE   = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   spi_counter_ctrl_n_if.slave bus
);
   localparam int            CW      = $clog2(CLR_PULSE + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLR_PULSE);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam bit            TGL     = (TOGGLE_MODE != 0);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_e;

   logic [NCH-1:0]   run_vec;
   logic [NCH-1:0]   clr_vec;
   logic [2*NCH-1:0] dbg_vec;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          prev_q;
      logic          clr_req;
      logic          rise;
      logic          go_run;
      logic          go_stop;

      always_comb begin
         clr_req = bus.i_clear[g] | bus.i_global_clear;
         rise    = bus.i_runstop[g] & ~prev_q;
         go_run  = TGL ? rise : bus.i_runstop[g];
         go_stop = TGL ? rise : ~bus.i_runstop[g];
         state_d = state_q;
         cnt_d   = '0;
         case (state_q)
            ST_STOP: begin
               if (clr_req) begin
                  state_d = ST_CLEAR;
                  cnt_d   = CNT_ONE;
               end else if (go_run) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (clr_req) begin
                  state_d = ST_CLEAR;
                  cnt_d   = CNT_ONE;
               end else if (go_stop) begin
                  state_d = ST_STOP;
               end
            end
            ST_CLEAR: begin
               // Hold saturates so a long clear request just extends the pulse.
               if (cnt_q == CNT_MAX) begin
                  cnt_d = cnt_q;
                  if (!clr_req) begin
                     state_d = ST_STOP;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = ST_STOP;
            end
         endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            state_q <= ST_STOP;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= bus.i_runstop[g];
         end
      end

      assign run_vec[g]         = (state_q == ST_RUN);
      assign clr_vec[g]         = (state_q == ST_CLEAR);
      assign dbg_vec[2*g +: 2]  = state_q;
   end

   assign bus.o_runstop   = run_vec;
   assign bus.o_clear     = clr_vec;
   assign bus.o_any_run   = |run_vec;
   assign bus.o_dbg_state = dbg_vec;
endmodule

// File: tb/tb_spi_counter_ctrl_n.sv
// Bench for spi_counter_ctrl_n: a level-mode and a toggle-mode instance share one stimulus
// stream and are checked against hand vectors and a deadline-based reference model.
module tb_spi_counter_ctrl_n;
   localparam int NCH       = 4;
   localparam int CLR_PULSE = 4;

   logic clk;
   logic reset_n;

   spi_counter_ctrl_n_if #(.NCH(NCH)) lvl_if ();
   spi_counter_ctrl_n_if #(.NCH(NCH)) tgl_if ();

   spi_counter_ctrl_n #(.NCH(NCH), .TOGGLE_MODE(0), .CLR_PULSE(CLR_PULSE)) dut_lvl (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (lvl_if.slave)
   );

   spi_counter_ctrl_n #(.NCH(NCH), .TOGGLE_MODE(1), .CLR_PULSE(CLR_PULSE)) dut_tgl (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (tgl_if.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: index 0 = level mode, 1 = toggle mode
   logic [3:0] m_run [2];
   logic [3:0] m_clr [2];
   logic [3:0] m_prev[2];
   int         m_start[2][4];
   int         cyc;

   typedef struct {
      logic [3:0] rs;
      logic [3:0] clr;
      logic       g;
      logic [3:0] exp_run;
      logic [3:0] exp_clr;
   } vec_t;

   vec_t tbl_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_run[m]  = '0;
         m_clr[m]  = '0;
         m_prev[m] = '0;
         for (int c = 0; c < 4; c++) m_start[m][c] = 0;
      end
      cyc = 0;
   endtask

   // A clear that starts at edge k owes output through edge k+CLR_PULSE-1 and
   // is extended for as long as the request stays high; exit always lands in STOP.
   task automatic model_step(input logic [3:0] rs, input logic [3:0] clr, input logic g);
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 4; c++) begin
            logic req;
            logic rise;
            req  = clr[c] | g;
            rise = rs[c] & ~m_prev[m][c];
            if (req) begin
               if (!m_clr[m][c]) m_start[m][c] = cyc;
               m_clr[m][c] = 1'b1;
               m_run[m][c] = 1'b0;
            end else if (m_clr[m][c]) begin
               if (cyc - m_start[m][c] >= CLR_PULSE) m_clr[m][c] = 1'b0;
            end else if (m == 0) begin
               m_run[m][c] = rs[c];
            end else begin
               m_run[m][c] = m_run[m][c] ^ rise;
            end
            m_prev[m][c] = rs[c];
         end
      end
      cyc++;
   endtask

   task automatic compare_model();
      check("model_lvl", {7'd0, lvl_if.o_any_run, lvl_if.o_runstop, lvl_if.o_clear},
            {7'd0, |m_run[0], m_run[0], m_clr[0]});
      check("model_tgl", {7'd0, tgl_if.o_any_run, tgl_if.o_runstop, tgl_if.o_clear},
            {7'd0, |m_run[1], m_run[1], m_clr[1]});
      check("excl", {8'd0, (lvl_if.o_runstop & lvl_if.o_clear), (tgl_if.o_runstop & tgl_if.o_clear)},
            16'd0);
   endtask

   // driver tasks
   task automatic set_in(input logic [3:0] rs, input logic [3:0] clr, input logic g);
      lvl_if.i_runstop      = rs;
      lvl_if.i_clear        = clr;
      lvl_if.i_global_clear = g;
      tgl_if.i_runstop      = rs;
      tgl_if.i_clear        = clr;
      tgl_if.i_global_clear = g;
   endtask

   task automatic apply(input logic [3:0] rs, input logic [3:0] clr, input logic g);
      set_in(rs, clr, g);
      @(posedge clk);
      model_step(rs, clr, g);
      #1;
      compare_model();
   endtask

   task automatic check_all_zero(input string name);
      check(name, {6'd0, lvl_if.o_any_run, tgl_if.o_any_run, lvl_if.o_runstop | tgl_if.o_runstop,
                   lvl_if.o_clear | tgl_if.o_clear}, 16'd0);
   endtask

   task automatic do_reset(input logic [3:0] rs_hold);
      reset_n = 1'b0;
      set_in(rs_hold, 4'd0, 1'b0);
      model_reset();
      #1;
      check_all_zero("reset_outputs");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic add(input logic [3:0] rs, input logic [3:0] clr, input logic g,
                      input logic [3:0] er, input logic [3:0] ec);
      vec_t v;
      v.rs = rs; v.clr = clr; v.g = g; v.exp_run = er; v.exp_clr = ec;
      tbl_q.push_back(v);
   endtask

   task automatic fill_table();
      // two channels run for 3 cycles, then drop
      add(4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0000);
      add(4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0000);
      add(4'b0101, 4'b0000, 1'b0, 4'b0101, 4'b0000);
      add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      // ch2 running, 1-cycle clear -> 4-cycle hold, STOP, then RUN again
      add(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
      add(4'b0100, 4'b0100, 1'b0, 4'b0000, 4'b0100);
      for (int i = 0; i < 3; i++) add(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100);
      add(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      add(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0000);
      add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      // ch1 clear held 9 cycles with run requested
      for (int i = 0; i < 9; i++) add(4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0010);
      add(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      add(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000);
      add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      // global clear with mixed RUN/STOP and an ignored run edge on ch1
      add(4'b1001, 4'b0000, 1'b0, 4'b1001, 4'b0000);
      add(4'b1001, 4'b0000, 1'b1, 4'b0000, 4'b1111);
      for (int i = 0; i < 3; i++) add(4'b1011, 4'b0000, 1'b0, 4'b0000, 4'b1111);
      add(4'b1001, 4'b0000, 1'b0, 4'b0000, 4'b0000);
      add(4'b1001, 4'b0000, 1'b0, 4'b1001, 4'b0000);
      add(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000);
   endtask

   initial begin
      logic [3:0] rs_r;
      logic [3:0] clr_bits;
      int         hold_cnt;

      reset_n = 1'b0;
      set_in(4'd0, 4'd0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_idle");
      reset_n = 1'b1;

      // table-driven vectors (hand expectations for the level-mode instance)
      fill_table();
      foreach (tbl_q[i]) begin
         apply(tbl_q[i].rs, tbl_q[i].clr, tbl_q[i].g);
         check($sformatf("tbl_lvl[%0d]", i), {8'd0, lvl_if.o_runstop, lvl_if.o_clear},
               {8'd0, tbl_q[i].exp_run, tbl_q[i].exp_clr});
         check($sformatf("tbl_any[%0d]", i), {15'd0, lvl_if.o_any_run}, {15'd0, |tbl_q[i].exp_run});
      end

      // toggle: pulse starts ch0, a later rise stops it, holding high does nothing more
      do_reset(4'd0);
      apply(4'b0001, 4'd0, 1'b0);
      check("tgl_start", {12'd0, tgl_if.o_runstop}, 16'h0001);
      repeat (9) apply(4'b0000, 4'd0, 1'b0);
      check("tgl_hold_run", {12'd0, tgl_if.o_runstop}, 16'h0001);
      apply(4'b0001, 4'd0, 1'b0);
      check("tgl_stop", {12'd0, tgl_if.o_runstop}, 16'h0000);
      repeat (5) apply(4'b0001, 4'd0, 1'b0);
      check("tgl_no_retoggle", {12'd0, tgl_if.o_runstop}, 16'h0000);
      apply(4'b0000, 4'd0, 1'b0);

      // toggle: ch2 running, 1-cycle clear -> exactly 4 clear cycles then STOP
      apply(4'b0100, 4'd0, 1'b0);
      check("tgl_ch2_run", {12'd0, tgl_if.o_runstop}, 16'h0004);
      apply(4'b0000, 4'b0100, 1'b0);
      check("tgl_clr_1", {8'd0, tgl_if.o_runstop, tgl_if.o_clear}, 16'h0004);
      for (int i = 2; i <= 4; i++) begin
         apply(4'b0000, 4'd0, 1'b0);
         check($sformatf("tgl_clr_%0d", i), {8'd0, tgl_if.o_runstop, tgl_if.o_clear}, 16'h0004);
      end
      apply(4'b0000, 4'd0, 1'b0);
      check("tgl_clr_done", {8'd0, tgl_if.o_runstop, tgl_if.o_clear}, 16'h0000);
      apply(4'b0000, 4'd0, 1'b0);
      check("tgl_stays_stop", {8'd0, tgl_if.o_runstop, tgl_if.o_clear}, 16'h0000);

      // reset in the 2nd cycle of a clear hold cuts it off with no remnant
      apply(4'b0000, 4'b0100, 1'b0);
      apply(4'b0000, 4'b0000, 1'b0);
      check("hold_cycle2", {12'd0, lvl_if.o_clear & tgl_if.o_clear}, 16'h0004);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all_zero("async_reset_mid_clear");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply(4'b0000, 4'd0, 1'b0);
         check_all_zero($sformatf("post_reset_idle_%0d", i));
      end

      // run request already high at release counts as a rise in toggle mode
      do_reset(4'b1000);
      apply(4'b1000, 4'd0, 1'b0);
      check("release_high", {8'd0, lvl_if.o_runstop, tgl_if.o_runstop}, 16'h0088);
      apply(4'b1000, 4'd0, 1'b0);
      check("release_high_2", {12'd0, tgl_if.o_runstop}, 16'h0008);

      // randomized stimulus against the reference model
      hold_cnt = 0;
      clr_bits = '0;
      for (int i = 0; i < 400; i++) begin
         rs_r = 4'($urandom_range(0, 15));
         if (hold_cnt == 0 && $urandom_range(0, 11) == 0) begin
            clr_bits = 4'($urandom_range(1, 15));
            hold_cnt = $urandom_range(1, 10);
         end
         if (hold_cnt > 0) begin
            apply(rs_r, clr_bits, 1'b0);
            hold_cnt--;
         end else begin
            apply(rs_r, 4'd0, ($urandom_range(0, 29) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
